stump_sequencer: RTL and testbench

STUMP_SEQUENCER -- requirements
Module: stump_sequencer

---
 rtl/stump_pkg.sv | 22 ++
 rtl/stump_sequencer.sv | 165 ++++++++++++++++
 tb/tb_stump_sequencer.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/stump_pkg.sv
// Shared Stump definitions.
//
// Holds the phase codes the sequencer sends to the control decoder and the
// opcode field values the sequencer needs to recognise. Both the sequencer
// and the decoder import this package, so the encodings live in one place.
package stump_pkg;

    // Phase codes carried on the sequencer's 'state' output.
    localparam logic [1:0] PHASE_FETCH   = 2'b00;
    localparam logic [1:0] PHASE_EXECUTE = 2'b01;
    localparam logic [1:0] PHASE_MEMORY  = 2'b10;

    // Instruction register bits [15:13] for a load/store.
    localparam logic [2:0] OP_LDST = 3'b110;

    // True when the opcode field selects a load/store, which needs a
    // separate memory phase after execute.
    function automatic logic is_ldst(input logic [2:0] op);
        return op == OP_LDST;
    endfunction

endpackage : stump_pkg

// File: rtl/stump_sequencer.sv
// Stump instruction sequencer.
//
// Walks each instruction through FETCH -> EXECUTE [-> MEMORY] and counts
// retirements. A halt request is honoured only at instruction boundaries;
// while halted, a step request runs exactly one instruction and returns to
// the halted state.
//
// Ports
//   clk         system clock, all state updates on the rising edge
//   rst_n       asynchronous active-low reset
//   mem_ready   memory handshake, 1 = current access completes this cycle
//   ir_op       instruction register bits [15:13]
//   halt_req    level request to halt at the next instruction boundary
//   step_req    one-cycle pulse, run one instruction while halted
//   state       phase code to the control decoder (FETCH/EXECUTE/MEMORY)
//   ir_en       instruction register load enable
//   commit      register-file / PC / CC write enable for this cycle
//   halted      1 while the core is halted
//   instr_count number of retired instructions, wraps at 16 bits
module stump_sequencer
    import stump_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        mem_ready,
    input  logic [2:0]  ir_op,
    input  logic        halt_req,
    input  logic        step_req,
    output logic [1:0]  state,
    output logic        ir_en,
    output logic        commit,
    output logic        halted,
    output logic [15:0] instr_count
);

    // Internal encoding is private; the decoder only ever sees phase codes.
    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_EXEC  = 2'd1,
        S_MEM   = 2'd2,
        S_HALT  = 2'd3
    } seq_state_t;

    seq_state_t state_q;
    seq_state_t state_d;
    logic       step_mode_q;
    logic       step_mode_d;
    logic       boundary;

    // ------------------------------------------------------------------
    // State, step flag and retirement counter
    // ------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every
    // register samples the pre-edge values of the others.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_FETCH;
            step_mode_q <= 1'b0;
            instr_count <= 16'h0000;
        end else begin
            state_q     <= state_d;
            step_mode_q <= step_mode_d;
            if (boundary) begin
                // Natural 16-bit overflow gives the FFFF -> 0000 wrap.
                instr_count <= instr_count + 16'd1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    // NOTE: every signal written here gets a default first, so no path
    // through the case can leave one unassigned and infer a latch.
    always_comb begin
        state_d     = state_q;
        step_mode_d = step_mode_q;
        boundary    = 1'b0;

        unique case (state_q)
            S_FETCH: begin
                if (mem_ready) begin
                    state_d = S_EXEC;
                end
            end

            S_EXEC: begin
                // Execute always lasts one cycle; only loads/stores need
                // the memory phase before they can retire.
                if (is_ldst(ir_op)) begin
                    state_d = S_MEM;
                end else begin
                    boundary = 1'b1;
                end
            end

            S_MEM: begin
                if (mem_ready) begin
                    boundary = 1'b1;
                end
            end

            S_HALT: begin
                // Dropping halt_req resumes free running; a step in the
                // same cycle is meaningless and is ignored.
                if (!halt_req) begin
                    state_d = S_FETCH;
                end else if (step_req) begin
                    step_mode_d = 1'b1;
                    state_d     = S_FETCH;
                end
            end

            default: begin
                state_d = S_FETCH;
            end
        endcase

        // Instruction boundary: the only place (besides S_HALT) where
        // halt_req is looked at, so an instruction is never cut short.
        if (boundary) begin
            step_mode_d = 1'b0;
            state_d     = (halt_req || step_mode_q) ? S_HALT : S_FETCH;
        end
    end

    // ------------------------------------------------------------------
    // Output decode
    // ------------------------------------------------------------------
    // Driven from the registered state and mem_ready only, so there is no
    // combinational route from halt_req or step_req to any output. Reset
    // forces the idle values even while the fetch handshake is active.
    always_comb begin
        state  = PHASE_FETCH;
        ir_en  = 1'b0;
        commit = 1'b0;
        halted = 1'b0;

        if (rst_n) begin
            unique case (state_q)
                S_FETCH: begin
                    state  = PHASE_FETCH;
                    ir_en  = mem_ready;
                    commit = mem_ready;
                end
                S_EXEC: begin
                    state  = PHASE_EXECUTE;
                    commit = 1'b1;
                end
                S_MEM: begin
                    state  = PHASE_MEMORY;
                    commit = mem_ready;
                end
                S_HALT: begin
                    state  = PHASE_FETCH;
                    halted = 1'b1;
                end
                default: begin
                    state = PHASE_FETCH;
                end
            endcase
        end
    end

endmodule : stump_sequencer

// File: tb/tb_stump_sequencer.sv
// Self-checking bench for stump_sequencer: a table of per-cycle vectors
// followed by hand-written sequences for counter wrap and reset cases.
module tb_stump_sequencer;

    logic        clk;
    logic        rst_n;
    logic        mem_ready;
    logic [2:0]  ir_op;
    logic        halt_req;
    logic        step_req;
    logic [1:0]  state;
    logic        ir_en;
    logic        commit;
    logic        halted;
    logic [15:0] instr_count;

    int n_cmp = 0;
    int n_err = 0;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_LS  = 3'b110;

    stump_sequencer dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .mem_ready   (mem_ready),
        .ir_op       (ir_op),
        .halt_req    (halt_req),
        .step_req    (step_req),
        .state       (state),
        .ir_en       (ir_en),
        .commit      (commit),
        .halted      (halted),
        .instr_count (instr_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        mr;
        logic [2:0]  op;
        logic        h;
        logic        s;
        logic [1:0]  e_state;
        logic        e_ir_en;
        logic        e_commit;
        logic        e_halted;
        logic [15:0] e_count;
    } vec_t;

    vec_t vecs [26];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_outs(input string tag, input logic [1:0] st, input logic ie,
                              input logic cm, input logic hl, input logic [15:0] cnt);
        check({tag, ".state"},  32'(state),       32'(st));
        check({tag, ".ir_en"},  32'(ir_en),       32'(ie));
        check({tag, ".commit"}, 32'(commit),      32'(cm));
        check({tag, ".halted"}, 32'(halted),      32'(hl));
        check({tag, ".count"},  32'(instr_count), 32'(cnt));
    endtask

    // Apply inputs on the falling edge and sample 1 ns later, well away
    // from the rising edge where state changes.
    task automatic cycle(input logic mr, input logic [2:0] op, input logic h, input logic s);
        @(negedge clk);
        mem_ready = mr;
        ir_op     = op;
        halt_req  = h;
        step_req  = s;
        #1;
    endtask

    initial begin
        //            mr  op      h  s   state  ie cm hl count
        vecs[0]  = '{1'b1, OP_ADD, 0, 0, 2'b00, 1, 1, 0, 16'd0}; // ADD fetch
        vecs[1]  = '{1'b1, OP_ADD, 0, 0, 2'b01, 0, 1, 0, 16'd0}; // ADD exec, retires
        vecs[2]  = '{1'b1, OP_ADD, 0, 0, 2'b00, 1, 1, 0, 16'd1}; // LDST fetch
        vecs[3]  = '{1'b1, OP_LS,  0, 0, 2'b01, 0, 1, 0, 16'd1}; // LDST exec
        vecs[4]  = '{1'b0, OP_LS,  0, 0, 2'b10, 0, 0, 0, 16'd1}; // mem wait 1
        vecs[5]  = '{1'b0, OP_LS,  0, 0, 2'b10, 0, 0, 0, 16'd1}; // mem wait 2
        vecs[6]  = '{1'b0, OP_LS,  0, 0, 2'b10, 0, 0, 0, 16'd1}; // mem wait 3
        vecs[7]  = '{1'b1, OP_LS,  0, 0, 2'b10, 0, 1, 0, 16'd1}; // mem done, retires
        vecs[8]  = '{1'b0, OP_ADD, 0, 0, 2'b00, 0, 0, 0, 16'd2}; // fetch wait
        vecs[9]  = '{1'b0, OP_ADD, 0, 0, 2'b00, 0, 0, 0, 16'd2}; // fetch wait
        vecs[10] = '{1'b1, OP_ADD, 0, 0, 2'b00, 1, 1, 0, 16'd2}; // fetch done
        vecs[11] = '{1'b1, OP_LS,  0, 0, 2'b01, 0, 1, 0, 16'd2}; // LDST exec
        vecs[12] = '{1'b0, OP_LS,  1, 0, 2'b10, 0, 0, 0, 16'd2}; // halt_req in MEM
        vecs[13] = '{1'b1, OP_LS,  1, 0, 2'b10, 0, 1, 0, 16'd2}; // completes, then halt
        vecs[14] = '{1'b1, OP_ADD, 1, 0, 2'b00, 0, 0, 1, 16'd3}; // halted
        vecs[15] = '{1'b1, OP_ADD, 1, 0, 2'b00, 0, 0, 1, 16'd3}; // stays halted
        vecs[16] = '{1'b1, OP_ADD, 1, 1, 2'b00, 0, 0, 1, 16'd3}; // step pulse
        vecs[17] = '{1'b1, OP_ADD, 0, 0, 2'b00, 1, 1, 0, 16'd3}; // stepped fetch
        vecs[18] = '{1'b1, OP_ADD, 0, 1, 2'b01, 0, 1, 0, 16'd3}; // step in exec ignored
        vecs[19] = '{1'b1, OP_ADD, 1, 0, 2'b00, 0, 0, 1, 16'd4}; // back to halt via step
        vecs[20] = '{1'b1, OP_ADD, 0, 1, 2'b00, 0, 0, 1, 16'd4}; // resume, step ignored
        vecs[21] = '{1'b1, OP_ADD, 0, 0, 2'b00, 1, 1, 0, 16'd4}; // fetch
        vecs[22] = '{1'b1, OP_ADD, 0, 1, 2'b01, 0, 1, 0, 16'd4}; // exec, stray step
        vecs[23] = '{1'b1, OP_ADD, 0, 0, 2'b00, 1, 1, 0, 16'd5}; // free running
        vecs[24] = '{1'b1, OP_ADD, 1, 0, 2'b01, 0, 1, 0, 16'd5}; // halt at boundary
        vecs[25] = '{1'b1, OP_ADD, 1, 0, 2'b00, 0, 0, 1, 16'd6}; // halted

        // Reset: outputs idle even with the fetch handshake active.
        rst_n     = 1'b0;
        mem_ready = 1'b1;
        ir_op     = OP_ADD;
        halt_req  = 1'b0;
        step_req  = 1'b0;
        #2;
        check_outs("reset", 2'b00, 1'b0, 1'b0, 1'b0, 16'd0);
        mem_ready = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 26; i++) begin
            cycle(vecs[i].mr, vecs[i].op, vecs[i].h, vecs[i].s);
            check_outs($sformatf("vec%0d", i), vecs[i].e_state, vecs[i].e_ir_en,
                       vecs[i].e_commit, vecs[i].e_halted, vecs[i].e_count);
        end

        // Counter wrap: preload FFFF while halted (nothing writes the
        // counter in S_HALT), then single-step one instruction.
        @(negedge clk);
        force dut.instr_count = 16'hFFFF;
        #1;
        release dut.instr_count;
        #1;
        check("wrap.preload", 32'(instr_count), 32'hFFFF);
        cycle(1'b1, OP_ADD, 1'b1, 1'b1);
        check_outs("wrap.halt", 2'b00, 1'b0, 1'b0, 1'b1, 16'hFFFF);
        cycle(1'b1, OP_ADD, 1'b1, 1'b0);
        check_outs("wrap.fetch", 2'b00, 1'b1, 1'b1, 1'b0, 16'hFFFF);
        cycle(1'b1, OP_ADD, 1'b1, 1'b0);
        check_outs("wrap.exec", 2'b01, 1'b0, 1'b1, 1'b0, 16'hFFFF);
        cycle(1'b1, OP_ADD, 1'b1, 1'b0);
        check_outs("wrap.done", 2'b00, 1'b0, 1'b0, 1'b1, 16'h0000);

        // Reset in the middle of a memory wait: access abandoned, no count.
        cycle(1'b1, OP_ADD, 1'b0, 1'b0);               // halt -> fetch
        cycle(1'b1, OP_ADD, 1'b0, 1'b0);               // ADD fetch
        cycle(1'b1, OP_ADD, 1'b0, 1'b0);               // ADD exec
        cycle(1'b1, OP_LS,  1'b0, 1'b0);               // LDST fetch
        check_outs("rmem.fetch", 2'b00, 1'b1, 1'b1, 1'b0, 16'd1);
        cycle(1'b1, OP_LS,  1'b0, 1'b0);               // LDST exec
        cycle(1'b0, OP_LS,  1'b0, 1'b0);               // memory wait
        check_outs("rmem.wait", 2'b10, 1'b0, 1'b0, 1'b0, 16'd1);
        #2;
        mem_ready = 1'b1;
        rst_n     = 1'b0;
        #1;
        check_outs("rmem.reset", 2'b00, 1'b0, 1'b0, 1'b0, 16'd0);

        // First edge after release evaluates FETCH normally.
        @(negedge clk);
        rst_n = 1'b1;
        ir_op = OP_ADD;
        #1;
        check_outs("rel.fetch", 2'b00, 1'b1, 1'b1, 1'b0, 16'd0);
        cycle(1'b1, OP_ADD, 1'b0, 1'b0);
        check_outs("rel.exec", 2'b01, 1'b0, 1'b1, 1'b0, 16'd0);

        // Reset during a fetch wait state takes effect without a clock edge.
        cycle(1'b0, OP_ADD, 1'b0, 1'b0);
        check_outs("rfetch.wait", 2'b00, 1'b0, 1'b0, 1'b0, 16'd1);
        cycle(1'b0, OP_ADD, 1'b0, 1'b0);
        check_outs("rfetch.wait2", 2'b00, 1'b0, 1'b0, 1'b0, 16'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check_outs("rfetch.reset", 2'b00, 1'b0, 1'b0, 1'b0, 16'd0);

        // Reset while halted clears halted immediately.
        @(negedge clk);
        rst_n = 1'b1;
        cycle(1'b1, OP_ADD, 1'b1, 1'b0);               // fetch
        cycle(1'b1, OP_ADD, 1'b1, 1'b0);               // exec, halts
        cycle(1'b1, OP_ADD, 1'b1, 1'b0);
        check_outs("rhalt.halted", 2'b00, 1'b0, 1'b0, 1'b1, 16'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check_outs("rhalt.reset", 2'b00, 1'b0, 1'b0, 1'b0, 16'd0);
        @(negedge clk);
        rst_n    = 1'b1;
        halt_req = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    // Watchdog so the run always ends.
    initial begin
        #20000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule : tb_stump_sequencer
